// File: rtl/pipelined_bypass_adder_pkg.sv
// adder_pkg: shared defaults and configuration helpers for the pipelined bypass adder
package adder_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int BLOCK_DEF = 4;

    function automatic int nblk(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit cfg_ok(input int width, input int block);
        return block >= 2 && block <= 8 && width >= block && width % block == 0;
    endfunction
endpackage

// File: rtl/pipelined_bypass_adder_if.sv
// pipelined_bypass_adder_if: operand/result valid-ready bus; ovf exists only with ADDER_OVF_EN
interface pipelined_bypass_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_bypass_adder_bypass_block.sv
// bypass_block: combinational BLOCK-bit PG lookahead slice whose carry-out skips the block when all bits propagate
module bypass_block
    import adder_pkg::*;
#(
    parameter int BLOCK = BLOCK_DEF
) (
    input  logic [BLOCK-1:0] a_blk,
    input  logic [BLOCK-1:0] b_blk,
    input  logic             cin_blk,
    output logic [BLOCK-1:0] sum_blk,
    output logic             cout_blk,
    output logic             msb_cin
);
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;

    assign p = a_blk ^ b_blk;
    assign g = a_blk & b_blk;

    always_comb begin
        c[0] = cin_blk;
        for (int i = 0; i < BLOCK; i++) c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign sum_blk  = p ^ c[BLOCK-1:0];
    assign cout_blk = &p ? cin_blk : c[BLOCK];
    assign msb_cin  = c[BLOCK-1];
endmodule

// File: rtl/pipelined_bypass_adder.sv
// pipelined_bypass_adder: WIDTH-bit carry-skip adder, one register stage per BLOCK-bit slice, valid/ready both sides
// Optional signed-overflow output enabled by defining ADDER_OVF_EN.
module pipelined_bypass_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BLOCK = BLOCK_DEF
) (
    input logic                     clk,
    input logic                     rst_n,
    pipelined_bypass_adder_if.slave bus
);
    localparam int NBLK = nblk(WIDTH, BLOCK);

    if (!cfg_ok(WIDTH, BLOCK)) begin : g_bad_cfg
        $fatal(1, "pipelined_bypass_adder: WIDTH must be a multiple of BLOCK and BLOCK must be 2..8");
    end

    // acc[k] carries finished sum bits below block k+1 and still-unused A bits above it
    logic             vld   [NBLK];
    logic             carry [NBLK];
    logic [WIDTH-1:0] acc   [NBLK];
    logic [WIDTH-1:0] bq    [NBLK];
    logic             vsrc  [NBLK];
    logic             csrc  [NBLK];
    logic [WIDTH-1:0] asrc  [NBLK];
    logic [WIDTH-1:0] bsrc  [NBLK];
    logic [WIDTH-1:0] nacc  [NBLK];
    logic [BLOCK-1:0] sblk  [NBLK];
    logic             cblk  [NBLK];
    logic             mc    [NBLK];
    logic             stall;

    assign stall        = vld[NBLK-1] & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        localparam int LO = k * BLOCK;
        localparam logic [WIDTH-1:0] MASK = WIDTH'({BLOCK{1'b1}}) << LO;
        if (k == 0) begin : g_head
            assign vsrc[k] = bus.in_valid;
            assign asrc[k] = bus.a;
            assign bsrc[k] = bus.b;
            assign csrc[k] = bus.cin;
        end else begin : g_body
            assign vsrc[k] = vld[k-1];
            assign asrc[k] = acc[k-1];
            assign bsrc[k] = bq[k-1];
            assign csrc[k] = carry[k-1];
        end
        bypass_block #(.BLOCK(BLOCK)) u_blk (
            .a_blk   (asrc[k][LO+:BLOCK]),
            .b_blk   (bsrc[k][BLOCK-1:0]),
            .cin_blk (csrc[k]),
            .sum_blk (sblk[k]),
            .cout_blk(cblk[k]),
            .msb_cin (mc[k])
        );
        assign nacc[k] = (asrc[k] & ~MASK) | (WIDTH'(sblk[k]) << LO);
        // B is kept shifted down so the next block's slice is always at bit 0
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld[k]   <= 1'b0;
                carry[k] <= 1'b0;
                acc[k]   <= '0;
                bq[k]    <= '0;
            end else if (!stall) begin
                vld[k]   <= vsrc[k];
                carry[k] <= cblk[k];
                acc[k]   <= nacc[k];
                bq[k]    <= bsrc[k] >> BLOCK;
            end
        end
    end

    assign bus.out_valid = vld[NBLK-1];
    assign bus.sum       = acc[NBLK-1];
    assign bus.cout      = carry[NBLK-1];

`ifdef ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else if (!stall) ovf_q <= mc[NBLK-1] ^ cblk[NBLK-1];
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_mc;
    assign unused_mc = mc[NBLK-1];
`endif
endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// tb_pipelined_bypass_adder: scoreboard bench with directed and random traffic against an arithmetic model
module tb_pipelined_bypass_adder;
    localparam int W = 16;
    localparam int B = 4;
    localparam int N = W / B;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           t;
        bit           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_bypass_adder_if #(.WIDTH(W)) bus ();
    pipelined_bypass_adder #(.WIDTH(W), .BLOCK(B)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rst_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_cnt = rst_cnt + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                   input int t, input bit lat);
        exp_t e;
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        e.s = r[W-1:0];
        e.c = r[W];
        e.o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        e.t = t;
        e.lat = lat;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input bit ordy, input bit lat, output bit took);
        @(negedge clk);
        bus.in_valid = v;
        bus.a = a;
        bus.b = b;
        bus.cin = ci;
        bus.out_ready = ordy;
        #1;
        took = v && bus.in_ready && rst_n;
        if (took) q.push_back(model(a, b, ci, cyc, lat));
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input bit ordy, input bit lat);
        bit took = 0;
        for (int i = 0; i < 50 && !took; i++) drive(1'b1, a, b, ci, ordy, lat, took);
        check("send_accept", 32'(took), 32'd1);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit took;
        repeat (n) drive(1'b0, bus.a, bus.b, bus.cin, ordy, 1'b0, took);
    endtask

    initial begin
        exp_t e;
        bit pstall = 0;
        logic [W-1:0] psum = '0;
        logic pcout = 1'b0;
        int prst = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
                if (pstall && prst == rst_cnt) begin
                    check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_hold_result", {15'd0, bus.cout, bus.sum}, {15'd0, pcout, psum});
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_output", 32'(q.size()), 32'd1);
                    end else begin
                        e = q.pop_front();
                        check("result", {15'd0, bus.cout, bus.sum}, {15'd0, e.c, e.s});
`ifdef ADDER_OVF_EN
                        check("ovf", 32'(bus.ovf), 32'(e.o));
`endif
                        if (e.lat) check("latency", 32'(cyc - e.t), 32'(N));
                    end
                end
                pstall = bus.out_valid && !bus.out_ready;
                psum = bus.sum;
                pcout = bus.cout;
            end else begin
                pstall = 0;
            end
            prst = rst_cnt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit took;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_cout", 32'(bus.cout), 32'd0);
`ifdef ADDER_OVF_EN
        check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
        idle(6, 1'b1);
        send(16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1);
        send(16'h5555, 16'hAAAA, 1'b1, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1);

        send(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        idle(6, 1'b1);
        check("backpressure_drained", 32'(q.size()), 32'd0);

        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        idle(6, 1'b1);

        for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
        idle(2, 1'b0);
        check("stalled_before_reset", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_reset_sum", 32'(bus.sum), 32'd0);
        check("async_reset_cout", 32'(bus.cout), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, bus.a, bus.b, bus.cin, 1'b1, 1'b0, took);
            check("no_stale_after_reset", 32'(bus.out_valid), 32'd0);
        end

        for (int i = 0; i < 12000; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ~ra : W'($urandom);
            drive($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), $urandom_range(0, 3) != 0, 1'b0, took);
        end
        idle(12, 1'b1);
        check("final_drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
